// File: rtl/arcfour_pkg.sv
// Shared types for the RC4 key-search sequencer.
//   state_t : FSM states. The 3-bit encoding is exported on state_tap.
//   mode_t  : key-selection modes. The raw 2'b11 code folds into single mode.
package arcfour_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        RUN       = 3'd2,
        NEXT_KEY  = 3'd3,
        FOUND     = 3'd4,
        EXHAUSTED = 3'd5,
        ABORTED   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        MODE_SINGLE = 2'b00,
        MODE_FULL   = 2'b01,
        MODE_RANGE  = 2'b10
    } mode_t;

    // Map the raw mode input onto a legal mode. The unused code behaves as single.
    function automatic mode_t decode_mode(input logic [1:0] raw);
        mode_t m;
        case (raw)
            2'b01:   m = MODE_FULL;
            2'b10:   m = MODE_RANGE;
            default: m = MODE_SINGLE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/edge_detector.sv
// Rising-edge detector with a registered one-cycle pulse output.
//   clk   : clock
//   reset : asynchronous active-high reset (clears history and pulse)
//   sig   : level input
//   rise  : one-cycle pulse, registered, one cycle after sig goes 0->1
module edge_detector (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic rise
);

    logic sig_d_reg;
    logic rise_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sig_d_reg <= 1'b0;
            rise_reg  <= 1'b0;
        end else begin
            sig_d_reg <= sig;
            rise_reg  <= sig & ~sig_d_reg;
        end
    end

    assign rise = rise_reg;

endmodule

// File: rtl/arcfour_sequencer.sv
// RC4 key-search sequencer. Walks candidate keys through NUM_PHASES
// cascaded phase engines using a start/done handshake per phase.
//   clk, reset         : clock, asynchronous active-high reset
//   start              : level; a rising edge in IDLE launches a search
//   abort              : stops the search from LOAD / RUN / NEXT_KEY
//   mode               : 00 single, 01 full, 10 range, 11 single
//   switch_key         : key used in single mode
//   key_lo, key_hi     : first and last allowed candidate in range mode
//   phase_start        : one-hot start pulse to phase engine i
//   phase_done         : done pulse from phase engine i
//   decrypt_ok         : result, valid with the last phase_done
//   key                : candidate key driven to the engines
//   busy               : not IDLE
//   found / exhausted / aborted : sticky outcome flags
//   attempts           : completed evaluations, saturating
//   state_tap          : encoded FSM state
module arcfour_sequencer
    import arcfour_pkg::*;
#(
    parameter int RAM_WIDTH  = 8,
    parameter int KEY_LENGTH = 3,
    parameter int KEY_BITS   = 22,
    parameter int KEY_STRIDE = 1,
    parameter int KEY_OFFSET = 0,
    parameter int NUM_PHASES = 3
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             abort,
    input  logic [1:0]                       mode,
    input  logic [KEY_LENGTH*RAM_WIDTH-1:0]  switch_key,
    input  logic [KEY_BITS-1:0]              key_lo,
    input  logic [KEY_BITS-1:0]              key_hi,
    output logic [NUM_PHASES-1:0]            phase_start,
    input  logic [NUM_PHASES-1:0]            phase_done,
    input  logic                             decrypt_ok,
    output logic [KEY_LENGTH*RAM_WIDTH-1:0]  key,
    output logic                             busy,
    output logic                             found,
    output logic                             exhausted,
    output logic                             aborted,
    output logic [KEY_BITS-1:0]              attempts,
    output logic [2:0]                       state_tap
);

    localparam int KEY_W = KEY_LENGTH * RAM_WIDTH;
    localparam int IDX_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PHASES - 1);

    state_t                state_reg;
    mode_t                 mode_reg;
    logic [KEY_BITS-1:0]   key_lo_reg;
    logic [KEY_BITS-1:0]   key_hi_reg;
    logic [KEY_BITS-1:0]   cand_reg;
    logic [IDX_W-1:0]      idx_reg;
    logic                  launched_reg;   // start pulse of current phase already issued
    logic [KEY_W-1:0]      key_reg;
    logic                  found_reg;
    logic                  exhausted_reg;
    logic                  aborted_reg;
    logic [KEY_BITS-1:0]   attempts_reg;

    logic                  start_rise;
    logic [KEY_BITS-1:0]   init_cand;
    logic [KEY_BITS:0]     next_cand;
    logic [KEY_BITS:0]     limit;
    logic                  done_here;

    edge_detector u_start_edge (
        .clk   (clk),
        .reset (reset),
        .sig   (start),
        .rise  (start_rise)
    );

    always_comb begin
        case (mode_reg)
            MODE_FULL:  init_cand = KEY_BITS'(KEY_OFFSET);
            MODE_RANGE: init_cand = key_lo_reg;
            default:    init_cand = '0;
        endcase
    end

    // One extra bit so a stride that steps past the top of the key space
    // is seen as "beyond limit" rather than wrapping to a small candidate.
    assign next_cand = {1'b0, cand_reg} + (KEY_BITS+1)'(KEY_STRIDE);
    assign limit     = (mode_reg == MODE_RANGE) ? {1'b0, key_hi_reg}
                                                : {1'b0, {KEY_BITS{1'b1}}};

    // Done is only meaningful after this phase's start pulse went out.
    assign done_here = launched_reg && phase_done[idx_reg];

    // The start pulse is decoded from registered state but gated by abort so
    // that no engine is kicked off in a cycle that is leaving for ABORTED.
    generate
        for (genvar gi = 0; gi < NUM_PHASES; gi++) begin : g_phase_start
            assign phase_start[gi] = (state_reg == RUN) && !launched_reg && !abort
                                     && (idx_reg == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            mode_reg      <= MODE_SINGLE;
            key_lo_reg    <= '0;
            key_hi_reg    <= '0;
            cand_reg      <= '0;
            idx_reg       <= '0;
            launched_reg  <= 1'b0;
            key_reg       <= '0;
            found_reg     <= 1'b0;
            exhausted_reg <= 1'b0;
            aborted_reg   <= 1'b0;
            attempts_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_rise) begin
                        mode_reg      <= decode_mode(mode);
                        key_lo_reg    <= key_lo;
                        key_hi_reg    <= key_hi;
                        found_reg     <= 1'b0;
                        exhausted_reg <= 1'b0;
                        aborted_reg   <= 1'b0;
                        attempts_reg  <= '0;
                        state_reg     <= LOAD;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state_reg <= ABORTED;
                    end else begin
                        cand_reg     <= init_cand;
                        key_reg      <= (mode_reg == MODE_SINGLE) ? switch_key
                                                                  : KEY_W'(init_cand);
                        idx_reg      <= '0;
                        launched_reg <= 1'b0;
                        state_reg    <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_reg <= ABORTED;
                    end else begin
                        if (!launched_reg)
                            launched_reg <= 1'b1;
                        if (done_here) begin
                            if (idx_reg != LAST_IDX) begin
                                idx_reg      <= idx_reg + IDX_W'(1);
                                launched_reg <= 1'b0;
                            end else begin
                                if (attempts_reg != {KEY_BITS{1'b1}})
                                    attempts_reg <= attempts_reg + KEY_BITS'(1);
                                if (decrypt_ok)
                                    state_reg <= FOUND;
                                else if (mode_reg == MODE_SINGLE)
                                    state_reg <= EXHAUSTED;
                                else if (next_cand > limit)
                                    state_reg <= EXHAUSTED;
                                else
                                    state_reg <= NEXT_KEY;
                            end
                        end
                    end
                end
                NEXT_KEY: begin
                    if (abort) begin
                        state_reg <= ABORTED;
                    end else begin
                        cand_reg     <= next_cand[KEY_BITS-1:0];
                        key_reg      <= KEY_W'(next_cand[KEY_BITS-1:0]);
                        idx_reg      <= '0;
                        launched_reg <= 1'b0;
                        state_reg    <= RUN;
                    end
                end
                FOUND: begin
                    found_reg <= 1'b1;
                    state_reg <= IDLE;
                end
                EXHAUSTED: begin
                    exhausted_reg <= 1'b1;
                    state_reg     <= IDLE;
                end
                ABORTED: begin
                    aborted_reg <= 1'b1;
                    state_reg   <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign key       = key_reg;
    assign busy      = (state_reg != IDLE);
    assign found     = found_reg;
    assign exhausted = exhausted_reg;
    assign aborted   = aborted_reg;
    assign attempts  = attempts_reg;
    assign state_tap = state_reg;

endmodule

// File: tb/tb_arcfour_sequencer.sv
// Directed bench for arcfour_sequencer. Instance A uses the default
// parameters; instance B is a 4-bit full-search core (stride 4, offset 3).
// Only the selected instance sees start; the idle one ignores everything else.
module tb_arcfour_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b0;
    logic        start_drv = 1'b0;
    logic        abort_drv = 1'b0;
    logic [1:0]  mode_drv = 2'b00;
    logic [23:0] sk_drv = '0;
    logic [21:0] lo_drv = '0;
    logic [21:0] hi_drv = '0;
    logic [2:0]  pd_drv = '0;
    logic        ok_drv = 1'b0;

    logic [2:0]  ps_a, ps_b;
    logic [23:0] key_a, key_b;
    logic        busy_a, busy_b, found_a, found_b, exh_a, exh_b, abt_a, abt_b;
    logic [21:0] att_a;
    logic [3:0]  att_b;
    logic [2:0]  st_a, st_b;

    int tests = 0;
    int fails = 0;
    logic [23:0] keys [16];

    always #5 clk = ~clk;

    arcfour_sequencer u_a (
        .clk(clk), .reset(reset), .start(start_drv & ~sel), .abort(abort_drv),
        .mode(mode_drv), .switch_key(sk_drv), .key_lo(lo_drv), .key_hi(hi_drv),
        .phase_start(ps_a), .phase_done(pd_drv), .decrypt_ok(ok_drv), .key(key_a),
        .busy(busy_a), .found(found_a), .exhausted(exh_a), .aborted(abt_a),
        .attempts(att_a), .state_tap(st_a)
    );

    arcfour_sequencer #(.KEY_BITS(4), .KEY_STRIDE(4), .KEY_OFFSET(3)) u_b (
        .clk(clk), .reset(reset), .start(start_drv & sel), .abort(abort_drv),
        .mode(mode_drv), .switch_key(sk_drv), .key_lo(lo_drv[3:0]), .key_hi(hi_drv[3:0]),
        .phase_start(ps_b), .phase_done(pd_drv), .decrypt_ok(ok_drv), .key(key_b),
        .busy(busy_b), .found(found_b), .exhausted(exh_b), .aborted(abt_b),
        .attempts(att_b), .state_tap(st_b)
    );

    logic [2:0]  ps_m;
    logic [23:0] key_m;
    logic        busy_m, found_m, exh_m, abt_m;
    logic [31:0] att_m;
    logic [2:0]  st_m;
    assign ps_m   = sel ? ps_b : ps_a;
    assign key_m  = sel ? key_b : key_a;
    assign busy_m = sel ? busy_b : busy_a;
    assign found_m = sel ? found_b : found_a;
    assign exh_m  = sel ? exh_b : exh_a;
    assign abt_m  = sel ? abt_b : abt_a;
    assign att_m  = sel ? 32'(att_b) : 32'(att_a);
    assign st_m   = sel ? st_b : st_a;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch a search on the selected instance and act as the phase engines:
    // each phase_done arrives 5 cycles after its start pulse. decrypt_ok is
    // raised with the last done when ok_en and the key matches ok_key. If
    // abort_cand >= 0, abort is raised together with the last done of that
    // candidate index. Returns start->first phase_start latency, number of
    // candidates evaluated and total number of start pulses seen.
    task automatic search(input bit inst, input logic [1:0] md, input logic [21:0] lo,
                          input logic [21:0] hi, input logic [23:0] sk, input bit ok_en,
                          input logic [23:0] ok_key, input int abort_cand,
                          output int lat, output int n_eval, output int n_starts);
        int  ph, since;
        bit  waiting, seen_busy, done;
        sel = inst; mode_drv = md; lo_drv = lo; hi_drv = hi; sk_drv = sk;
        start_drv = 1'b1;
        lat = -1; n_eval = 0; n_starts = 0; ph = 0; since = 0;
        waiting = 0; seen_busy = 0; done = 0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            start_drv = 1'b0; pd_drv = '0; ok_drv = 1'b0; abort_drv = 1'b0;
            if (busy_m) seen_busy = 1;
            if (ps_m != 3'b000) begin
                n_starts++;
                if (lat < 0) lat = c + 1;
                check("phase_order", 32'(ps_m), 32'(1 << ph));
                if (ph == 0) begin
                    if (n_eval < 16) keys[n_eval] = key_m;
                    n_eval++;
                end
                waiting = 1; since = 0;
            end else if (waiting) begin
                since++;
                if (since == 5) begin
                    pd_drv = 3'(1 << ph);
                    if (ph == 2) begin
                        ok_drv = ok_en && (key_m == ok_key);
                        if (n_eval - 1 == abort_cand) abort_drv = 1'b1;
                    end
                    waiting = 0;
                    ph = (ph + 1) % 3;
                end
            end
            if (seen_busy && !busy_m) done = 1;
        end
        check("search_terminates", 32'(done), 32'd1);
    endtask

    initial begin
        int lat, ne, ns;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_state", 32'(st_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_key", 32'(key_a), 32'd0);
        check("rst_ps", 32'(ps_a), 32'd0);
        check("rst_flags", {29'd0, found_a, exh_a, abt_a}, 32'd0);
        check("rst_attempts", 32'(att_a), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // 1: single mode, found on the switch key
        search(0, 2'b00, 22'd0, 22'd0, 24'h0A0B0C, 1, 24'h0A0B0C, -1, lat, ne, ns);
        $display("[TB] single: lat=%0d evals=%0d key=%h found=%0d att=%0d", lat, ne, key_m, found_m, att_m);
        check("t1_latency", 32'(lat), 32'd3);
        check("t1_evals", 32'(ne), 32'd1);
        check("t1_starts", 32'(ns), 32'd3);
        check("t1_key_seen", 32'(keys[0]), 32'h0A0B0C);
        check("t1_key_out", 32'(key_m), 32'h0A0B0C);
        check("t1_found", 32'(found_m), 32'd1);
        check("t1_exhausted", 32'(exh_m), 32'd0);
        check("t1_attempts", att_m, 32'd1);
        check("t1_busy", 32'(busy_m), 32'd0);

        // 2: range 5..8, success on 7
        search(0, 2'b10, 22'd5, 22'd8, 24'h0, 1, 24'd7, -1, lat, ne, ns);
        $display("[TB] range: evals=%0d key=%h found=%0d att=%0d", ne, key_m, found_m, att_m);
        check("t2_evals", 32'(ne), 32'd3);
        check("t2_cand0", 32'(keys[0]), 32'd5);
        check("t2_cand1", 32'(keys[1]), 32'd6);
        check("t2_cand2", 32'(keys[2]), 32'd7);
        check("t2_found", 32'(found_m), 32'd1);
        check("t2_attempts", att_m, 32'd3);
        check("t2_key_out", 32'(key_m), 32'd7);

        // 3: full search on the 4-bit core, never succeeds
        search(1, 2'b01, 22'd0, 22'd0, 24'h0, 0, 24'h0, -1, lat, ne, ns);
        $display("[TB] full: evals=%0d exh=%0d att=%0d", ne, exh_m, att_m);
        check("t3_evals", 32'(ne), 32'd4);
        check("t3_cand0", 32'(keys[0]), 32'd3);
        check("t3_cand1", 32'(keys[1]), 32'd7);
        check("t3_cand2", 32'(keys[2]), 32'd11);
        check("t3_cand3", 32'(keys[3]), 32'd15);
        check("t3_exhausted", 32'(exh_m), 32'd1);
        check("t3_found", 32'(found_m), 32'd0);
        check("t3_attempts", att_m, 32'd4);

        // 4: abort together with the last done (and decrypt_ok) of candidate 6
        search(0, 2'b10, 22'd5, 22'd8, 24'h0, 1, 24'd6, 1, lat, ne, ns);
        $display("[TB] abort: evals=%0d starts=%0d abt=%0d found=%0d att=%0d", ne, ns, abt_m, found_m, att_m);
        check("t4_evals", 32'(ne), 32'd2);
        check("t4_starts", 32'(ns), 32'd6);
        check("t4_aborted", 32'(abt_m), 32'd1);
        check("t4_found", 32'(found_m), 32'd0);
        check("t4_attempts", att_m, 32'd1);

        // 5: start while busy is ignored; async reset mid-RUN
        sel = 0; mode_drv = 2'b00; sk_drv = 24'h445566; start_drv = 1'b1;
        @(negedge clk); start_drv = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t5_first_start", 32'(ps_m), 32'b001);
        @(negedge clk); start_drv = 1'b1;
        @(negedge clk); start_drv = 1'b0;
        @(negedge clk);
        check("t5_start_ignored", 32'(st_m), 32'd2);
        @(negedge clk); pd_drv = 3'b001;
        @(negedge clk); pd_drv = 3'b000;
        check("t5_second_start", 32'(ps_m), 32'b010);
        #1 reset = 1'b1;
        #1;
        check("t5_rst_ps", 32'(ps_m), 32'd0);
        check("t5_rst_state", 32'(st_m), 32'd0);
        check("t5_rst_busy", 32'(busy_m), 32'd0);
        check("t5_rst_key", 32'(key_m), 32'd0);
        check("t5_rst_att", att_m, 32'd0);
        check("t5_rst_flags", {29'd0, found_m, exh_m, abt_m}, 32'd0);
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        search(0, 2'b00, 22'd0, 22'd0, 24'h445566, 1, 24'h445566, -1, lat, ne, ns);
        $display("[TB] after reset: lat=%0d key=%h found=%0d", lat, key_m, found_m);
        check("t5_latency", 32'(lat), 32'd3);
        check("t5_found", 32'(found_m), 32'd1);
        check("t5_attempts", att_m, 32'd1);

        // 6: inverted range evaluates key_lo once
        search(0, 2'b10, 22'd9, 22'd4, 24'h0, 0, 24'h0, -1, lat, ne, ns);
        $display("[TB] inverted range: evals=%0d key=%h exh=%0d att=%0d", ne, key_m, exh_m, att_m);
        check("t6_evals", 32'(ne), 32'd1);
        check("t6_cand0", 32'(keys[0]), 32'd9);
        check("t6_exhausted", 32'(exh_m), 32'd1);
        check("t6_found", 32'(found_m), 32'd0);
        check("t6_attempts", att_m, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/arcfour_sequencer.md
Name: arcfour_sequencer

Overview:
- Parametrised successor to the single-core RC4 key-search controller. Sequences candidate keys through N cascaded phase engines (init / shuffle / decrypt or more) using a per-phase start/done handshake.
- Three key modes: single switch key, full search, bounded range search. Supports stride/offset key-space partitioning for multi-core builds, plus abort, sticky status and an attempt counter.
- Sits between the board-level top and the RAM phase engines. Drives the key bus consumed by those engines.

Parameters:
- RAM_WIDTH, 8, byte width of a key element
- KEY_LENGTH, 3, number of key bytes on the key bus
- KEY_BITS, 22, width of the candidate counter (searchable bits, LSB-aligned in the key bus); must be ≤ KEY_LENGTH*RAM_WIDTH
- KEY_STRIDE, 1, candidate increment (equals core count when partitioned)
- KEY_OFFSET, 0, first candidate in full-search mode (core index)
- NUM_PHASES, 3, number of phase engines handshaked in order

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- start  in  1  level; rising edge detected internally
- abort  in  1  level; stops search from any non-IDLE state
- mode  in  2  00 single, 01 full search, 10 range search, 11 treated as 00
- switch_key  in  KEY_LENGTH*RAM_WIDTH  key used in single mode
- key_lo  in  KEY_BITS  range-mode first candidate
- key_hi  in  KEY_BITS  range-mode last allowed candidate
- phase_start  out  NUM_PHASES  one-hot start pulse to phase engine i
- phase_done  in  NUM_PHASES  done pulse from phase engine i
- decrypt_ok  in  1  valid with phase_done[NUM_PHASES-1]
- key  out  KEY_LENGTH*RAM_WIDTH  current candidate key
- busy  out  1  high in any non-IDLE state
- found  out  1  sticky: key produced decrypt_ok
- exhausted  out  1  sticky: search space ended without success
- aborted  out  1  sticky: abort taken
- attempts  out  KEY_BITS  completed evaluations, saturating
- state_tap  out  3  encoded FSM state for debug

Behaviour:
- Reset: state IDLE. key, phase_start, found, exhausted, aborted, attempts, candidate and phase index all 0. busy 0. Edge-detector history cleared.
- Start edge in IDLE is accepted: mode, key_lo and key_hi are latched; found, exhausted, aborted and attempts are cleared; next state is LOAD. Start edges in other states are ignored.
- LOAD (1 cycle): candidate is set to 0 (single), KEY_OFFSET (full) or key_lo (range). key is switch_key in single mode, otherwise the zero-extended candidate. Phase index is set to 0. Next state is RUN.
- RUN: phase_start[idx] is high for exactly the first cycle of each phase, then the block waits for phase_done[idx]. phase_done on other indices is ignored.
- On phase_done[idx] with idx < NUM_PHASES-1: idx increments and the next phase starts on the following cycle. Phases never overlap.
- On phase_done[last]: attempts increments (saturating at all-ones) and decrypt_ok is sampled in the same cycle.
  - decrypt_ok=1 → FOUND.
  - Single mode → EXHAUSTED.
  - Otherwise next = candidate + KEY_STRIDE, computed at KEY_BITS+1 width. If next > limit (limit = key_hi for range, 2^KEY_BITS-1 for full), go to EXHAUSTED. Else go to NEXT_KEY.
- NEXT_KEY (1 cycle): candidate and key are updated, idx is set to 0, then RUN. key is stable for the whole evaluation of a candidate.
- Range mode with key_lo > key_hi: the key_lo candidate is still evaluated once, then EXHAUSTED.
- FOUND, EXHAUSTED, ABORTED: 1 cycle each; the matching sticky flag is set, then IDLE. key holds its last value until the next LOAD.
- Abort: if abort is high in LOAD, RUN or NEXT_KEY, the next state is ABORTED. Abort has priority over phase_done and decrypt_ok in the same cycle. No phase_start is issued in a cycle where abort is high. The attempts increment for that cycle is suppressed.
- Reset mid-search: immediate return to reset values. phase_start deasserts asynchronously.
- Latency: start edge to phase_start[0] is 3 cycles (edge detect, LOAD, RUN entry). Last phase_done to next candidate's phase_start[0] is 2 cycles.

Decomposition:
- Shared package arcfour_pkg holds: the state_t enum (IDLE, LOAD, RUN, NEXT_KEY, FOUND, EXHAUSTED, ABORTED; 3-bit encoding used for state_tap) and the mode_t enum (MODE_SINGLE, MODE_FULL, MODE_RANGE).
- One sub-module: the existing edge_detector, reused for start.
- Candidate/limit arithmetic stays inline.

Test Plan:
- Single mode, switch_key=24'h0A0B0C, each phase_done 5 cycles after its start, decrypt_ok=1 → phase_start pulses 0,1,2 in order; key=0A0B0C; found=1, attempts=1, busy drops.
- Range mode, key_lo=5, key_hi=8, STRIDE=1, decrypt_ok=1 only when key=7 → candidates 5,6,7 evaluated; found=1, attempts=3, key=7.
- Full search, KEY_BITS=4, STRIDE=4, OFFSET=3, decrypt_ok never → candidates 3,7,11,15; exhausted=1, attempts=4.
- Abort raised in the same cycle as phase_done[2] with decrypt_ok=1 → aborted=1, found=0, attempts unchanged, no further phase_start.
- Start pulse while busy, then async reset mid-RUN → start ignored; after reset all outputs 0, state_tap=IDLE; a fresh start runs normally with 3-cycle latency to phase_start[0].
- Range key_lo=9, key_hi=4 → one evaluation of key 9, then exhausted=1.
